// File: rtl/load_seq_gen.sv
// Stimulus generator for props_chk: buffers words in a 2-deep FIFO, issues each as a
// one-cycle load into a loadable up-counter, and keeps the d/d_r/q/load view the checker binds to.
module load_seq_gen #(
    parameter int WIDTH    = 16,
    parameter int MODEL_ID = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             cnt_en,
    output logic             load,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_r,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             push, pop, wrap;
    logic [WIDTH-1:0] d_q, d_r_q, q_q;
    logic             tc_q;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign wrap     = (state_q == RUN) && cnt_en && (q_q == ALL_ONES);
    assign count_d  = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // RUN only exits on the wrapping increment; queued words wait for it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != 2'd0) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (wrap) state_d = (count_q != 2'd0) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = (state_q == LOAD);
        pop  = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q   <= '0;
            d_r_q <= '0;
            q_q   <= '0;
            tc_q  <= 1'b0;
        end else begin
            if (pop) d_q <= mem_q[rd_ptr_q];
            if (state_q == LOAD)
                q_q <= d_q;
            else if (state_q == RUN && cnt_en)
                q_q <= q_q + WIDTH'(1);
            tc_q <= wrap;
            // Model 1 tracks d every cycle; other models refresh d_r only as a load retires.
            if (MODEL_ID == 1 || state_q == LOAD) d_r_q <= d_q;
        end
    end

    assign d   = d_q;
    assign d_r = d_r_q;
    assign q   = q_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_load_seq_gen.sv
// Directed bench for load_seq_gen: a 16-bit MODEL_ID=2 instance and a 4-bit MODEL_ID=1 instance.
module tb_load_seq_gen;

    logic        clk;
    logic        reset_n;
    logic        va, ra, ena, lda, tca;
    logic [15:0] da, dqa, dra, qa;
    logic        vb, rb, enb, ldb, tcb;
    logic [3:0]  db, dqb, drb, qb;

    int          n_vec;
    int          n_err;
    int          nl;
    logic [3:0]  lds [3];
    logic        acc;
    logic        prev_ld;
    logic [3:0]  prev_d;

    load_seq_gen #(.WIDTH(16), .MODEL_ID(2)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(va), .in_data(da), .in_ready(ra),
        .cnt_en(ena), .load(lda), .d(dqa), .d_r(dra), .q(qa), .tc(tca)
    );

    load_seq_gen #(.WIDTH(4), .MODEL_ID(1)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(vb), .in_data(db), .in_ready(rb),
        .cnt_en(enb), .load(ldb), .d(dqb), .d_r(drb), .q(qb), .tc(tcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b1;
        va = 0; da = '0; ena = 0;
        vb = 0; db = '0; enb = 0;

        // Power-on reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst_q",     32'(qa),  32'h0);
        chk("rst_load",  32'(lda), 32'h0);
        chk("rst_ready", 32'(ra),  32'h1);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Mid-RUN asynchronous reset with q=0x1234 and a full FIFO
        va = 1; da = 16'h1234;
        tick();
        va = 0;
        tick();
        tick();
        chk("run_q1234", 32'(qa), 32'h1234);
        va = 1; da = 16'h5555;
        tick();
        da = 16'h6666;
        tick();
        va = 0;
        chk("full_ready", 32'(ra), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q",     32'(qa),  32'h0);
        chk("arst_d",     32'(dqa), 32'h0);
        chk("arst_dr",    32'(dra), 32'h0);
        chk("arst_load",  32'(lda), 32'h0);
        chk("arst_tc",    32'(tca), 32'h0);
        chk("arst_ready", 32'(ra),  32'h1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_noload", 32'(lda), 32'h0);
        end
        chk("idle_q", 32'(qa), 32'h0);

        // Single load, MODEL_ID=2
        va = 1; da = 16'hA5A5;
        tick();
        va = 0;
        chk("a5_k_load",  32'(lda), 32'h0);
        chk("a5_k_ready", 32'(ra),  32'h1);
        tick();
        chk("a5_k1_load", 32'(lda), 32'h1);
        chk("a5_k1_d",    32'(dqa), 32'hA5A5);
        chk("a5_k1_q",    32'(qa),  32'h0);
        chk("a5_k1_dr",   32'(dra), 32'h0);
        tick();
        chk("a5_k2_load", 32'(lda), 32'h0);
        chk("a5_k2_q",    32'(qa),  32'hA5A5);
        chk("a5_k2_dr",   32'(dra), 32'hA5A5);
        tick();
        chk("a5_hold_q",  32'(qa),  32'hA5A5);
        chk("a5_hold_d",  32'(dqa), 32'hA5A5);

        // MODEL_ID=2 wrap into a queued load: d_r keeps the old word through LOAD
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        va = 1; da = 16'hFFFE;
        tick();
        da = 16'h1111;
        tick();
        va = 0; ena = 1;
        chk("w2_load", 32'(lda), 32'h1);
        chk("w2_d",    32'(dqa), 32'hFFFE);
        tick();
        chk("w2_q0",   32'(qa),  32'hFFFE);
        chk("w2_dr0",  32'(dra), 32'hFFFE);
        tick();
        chk("w2_q1",   32'(qa),  32'hFFFF);
        chk("w2_tc1",  32'(tca), 32'h0);
        tick();
        chk("w2_qwrap",  32'(qa),  32'h0);
        chk("w2_tcwrap", 32'(tca), 32'h1);
        chk("w2_ldwrap", 32'(lda), 32'h1);
        chk("w2_dwrap",  32'(dqa), 32'h1111);
        chk("w2_drwrap", 32'(dra), 32'hFFFE);
        tick();
        ena = 0;
        chk("w2_qnew",  32'(qa),  32'h1111);
        chk("w2_drnew", 32'(dra), 32'h1111);
        chk("w2_tcoff", 32'(tca), 32'h0);

        // WIDTH=4 count and wrap to IDLE
        vb = 1; db = 4'hD;
        tick();
        vb = 0; enb = 1;
        tick();
        chk("c_load", 32'(ldb), 32'h1);
        chk("c_d",    32'(dqb), 32'hD);
        chk("c_dr0",  32'(drb), 32'h0);
        tick();
        chk("c_qD",   32'(qb),  32'hD);
        chk("c_drD",  32'(drb), 32'hD);
        chk("c_tcD",  32'(tcb), 32'h0);
        tick();
        chk("c_qE",   32'(qb),  32'hE);
        tick();
        chk("c_qF",   32'(qb),  32'hF);
        chk("c_tcF",  32'(tcb), 32'h0);
        tick();
        chk("c_q0",   32'(qb),  32'h0);
        chk("c_tc0",  32'(tcb), 32'h1);
        chk("c_ld0",  32'(ldb), 32'h0);
        tick();
        chk("c_idle_q",  32'(qb),  32'h0);
        chk("c_idle_tc", 32'(tcb), 32'h0);
        tick();
        chk("c_idle_q2", 32'(qb),  32'h0);

        // Back-to-back loads through the wrap
        vb = 1; db = 4'hE;
        tick();
        db = 4'h3;
        tick();
        vb = 0;
        chk("b_load", 32'(ldb), 32'h1);
        chk("b_dE",   32'(dqb), 32'hE);
        tick();
        chk("b_qE",   32'(qb),  32'hE);
        tick();
        chk("b_qF",   32'(qb),  32'hF);
        tick();
        chk("b_q0",   32'(qb),  32'h0);
        chk("b_tc",   32'(tcb), 32'h1);
        chk("b_ld",   32'(ldb), 32'h1);
        chk("b_d3",   32'(dqb), 32'h3);
        tick();
        enb = 0;
        chk("b_q3",   32'(qb),  32'h3);
        chk("b_ld3",  32'(ldb), 32'h0);
        chk("b_tc3",  32'(tcb), 32'h0);

        // FIFO full while in RUN: words 1,2,3 offered back to back
        vb = 1; db = 4'h1;
        tick();
        chk("f_ready1", 32'(rb), 32'h1);
        db = 4'h2;
        tick();
        chk("f_ready2", 32'(rb), 32'h0);
        db = 4'h3;
        tick();
        chk("f_ready3", 32'(rb), 32'h0);
        enb = 1;
        nl = 0;
        for (int i = 0; i < 200 && nl < 3; i++) begin
            acc = vb && rb;
            tick();
            if (acc) vb = 0;
            if (ldb) begin
                lds[nl] = dqb;
                nl++;
            end
        end
        enb = 0;
        vb = 0;
        chk("f_nloads", 32'(nl), 32'd3);
        chk("f_ord0", 32'(lds[0]), 32'h1);
        chk("f_ord1", 32'(lds[1]), 32'h2);
        chk("f_ord2", 32'(lds[2]), 32'h3);

        // MODEL_ID=1 random traffic: d_r is always last cycle's d, loads never adjacent
        prev_d  = dqb;
        prev_ld = ldb;
        for (int i = 0; i < 1000; i++) begin
            vb  = 1'($urandom_range(0, 1));
            db  = 4'($urandom);
            enb = 1'($urandom_range(0, 1));
            tick();
            chk("r_dr", 32'(drb), 32'(prev_d));
            chk("r_ldgap", 32'(ldb && prev_ld), 32'h0);
            prev_d  = dqb;
            prev_ld = ldb;
        end
        vb = 0; enb = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
